// File: rtl/lexington.sv
// lexington: shared Lexington core constants and bus helpers.
package lexington;
    localparam int IRQ_PENDING_OFS = 'h00;
    localparam int IRQ_ENABLE_OFS  = 'h01;
    localparam int IRQ_MODE_OFS    = 'h02;
    localparam int IRQ_THRESH_OFS  = 'h03;
    localparam int IRQ_CLAIM_OFS   = 'h04;
    localparam int IRQ_INSVC_OFS   = 'h05;
    localparam int IRQ_PRIO_BASE   = 'h20;
    localparam int IRQ_MAX_SRC     = 31;
    localparam logic [31:0] DEFAULT_IRQ_BASE_ADDR = 32'h0200_1000;

    function automatic logic [31:0] apply_strobe(input logic [31:0] old_v, input logic [31:0] new_v,
                                                 input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/irq_gateway.sv
// irq_gateway: per-source synchroniser, edge/level detection and latched pending flag.
module irq_gateway #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic in_service,
    input  logic clr,
    output logic pending
);
    logic s, prev, set;
    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = src;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync;
        always_ff @(posedge clk or posedge rst)
            if (rst) sync <= '0;
            else sync <= (sync << 1) | SYNC_STAGES'(src);
        assign s = sync[SYNC_STAGES-1];
    end
    // a level source being claimed this cycle counts as in service already
    always_comb set = edge_mode ? s & ~prev : s & ~in_service & ~clr;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev    <= s;
            pending <= set | (pending & ~clr);
        end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped platform interrupt controller with priority arbitration
// and claim/complete handshaking, driving one machine external interrupt request.
module irq_ctrl
    import lexington::*;
#(
    parameter int NUM_SRC     = 10,
    parameter int PRIO_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    src,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    input  logic [3:0]            wr_strobe,
    output logic [31:0]           rd_data,
    output logic                  irq
);
    localparam logic [ADDR_WIDTH-1:0] A_PEND  = ADDR_WIDTH'(IRQ_PENDING_OFS);
    localparam logic [ADDR_WIDTH-1:0] A_EN    = ADDR_WIDTH'(IRQ_ENABLE_OFS);
    localparam logic [ADDR_WIDTH-1:0] A_MODE  = ADDR_WIDTH'(IRQ_MODE_OFS);
    localparam logic [ADDR_WIDTH-1:0] A_THR   = ADDR_WIDTH'(IRQ_THRESH_OFS);
    localparam logic [ADDR_WIDTH-1:0] A_CLAIM = ADDR_WIDTH'(IRQ_CLAIM_OFS);
    localparam logic [ADDR_WIDTH-1:0] A_INSVC = ADDR_WIDTH'(IRQ_INSVC_OFS);
    localparam logic [ADDR_WIDTH-1:0] A_PRIO  = ADDR_WIDTH'(IRQ_PRIO_BASE);

    logic [NUM_SRC:1]      pending, enable, edge_mode, in_service, clr;
    logic [PRIO_WIDTH-1:0] thresh, best_prio, prio_rd;
    logic [PRIO_WIDTH-1:0] prio [1:NUM_SRC];
    logic [4:0]            best_id;
    logic [ADDR_WIDTH-1:0] pidx;
    logic                  prio_hit, claim, complete;
    logic [31:0]           cur, merged;
    logic                  unused_bits;

    for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
        irq_gateway #(.SYNC_STAGES(SYNC_STAGES)) u_gw (
            .clk       (clk),
            .rst       (rst),
            .src       (src[g-1]),
            .edge_mode (edge_mode[g]),
            .in_service(in_service[g]),
            .clr       (clr[g]),
            .pending   (pending[g])
        );
    end

    // strict '>' keeps the lowest ID on equal priorities
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 1; i <= NUM_SRC; i++)
            if (pending[i] && enable[i] && !in_service[i] && prio[i] > thresh && prio[i] > best_prio) begin
                best_id   = 5'(i);
                best_prio = prio[i];
            end
    end

    always_comb begin
        claim    = rd_en && addr == A_CLAIM && best_id != '0;
        complete = wr_en && addr == A_CLAIM && wr_strobe[0];
        clr      = '0;
        for (int i = 1; i <= NUM_SRC; i++) clr[i] = claim && best_id == 5'(i);
    end

    always_comb begin
        pidx     = addr - A_PRIO;
        prio_hit = addr >= A_PRIO && pidx != '0 && pidx <= ADDR_WIDTH'(NUM_SRC);
        prio_rd  = '0;
        for (int i = 1; i <= NUM_SRC; i++)
            if (pidx == ADDR_WIDTH'(i)) prio_rd = prio[i];
        cur = addr == A_PEND  ? 32'({pending, 1'b0})    :
              addr == A_EN    ? 32'({enable, 1'b0})     :
              addr == A_MODE  ? 32'({edge_mode, 1'b0})  :
              addr == A_THR   ? 32'(thresh)             :
              addr == A_CLAIM ? 32'(best_id)            :
              addr == A_INSVC ? 32'({in_service, 1'b0}) :
              prio_hit        ? 32'(prio_rd)            : '0;
        rd_data = rd_en ? cur : '0;
        merged  = apply_strobe(cur, wr_data, wr_strobe);
    end

    assign unused_bits = ^{merged, wr_data};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            enable     <= '0;
            edge_mode  <= '0;
            thresh     <= '0;
            in_service <= '0;
            irq        <= 1'b0;
            for (int i = 1; i <= NUM_SRC; i++) prio[i] <= '0;
        end else begin
            irq <= best_id != '0;
            if (wr_en && addr == A_EN) enable <= merged[NUM_SRC:1];
            if (wr_en && addr == A_MODE) edge_mode <= merged[NUM_SRC:1];
            if (wr_en && addr == A_THR) thresh <= merged[PRIO_WIDTH-1:0];
            for (int i = 1; i <= NUM_SRC; i++) begin
                if (wr_en && prio_hit && pidx == ADDR_WIDTH'(i)) prio[i] <= merged[PRIO_WIDTH-1:0];
                in_service[i] <= clr[i] | (in_service[i] & ~(complete && wr_data[4:0] == 5'(i)));
            end
        end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl at default parameters.
module tb_irq_ctrl;
    logic        clk, rst, rd_en, wr_en, irq;
    logic [9:0]  src;
    logic [5:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic [3:0]  wr_strobe;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    irq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_strobe(wr_strobe),
        .rd_data  (rd_data),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed 0x%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    // all bus tasks start and end on a falling edge and span one rising edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        wr_en = 1'b1; addr = a; wr_data = d; wr_strobe = s;
        @(negedge clk);
        wr_en = 1'b0; wr_strobe = 4'h0;
    endtask

    task automatic chk_rd(input string tag, input logic [5:0] a, input logic [31:0] e);
        logic [31:0] d;
        sb.push_back('{tag, e});
        rd_en = 1'b1; addr = a;
        #1 d = rd_data;
        @(negedge clk);
        rd_en = 1'b0;
        compare(d);
    endtask

    task automatic chk_irq(input string tag, input logic e);
        sb.push_back('{tag, {31'b0, e}});
        compare({31'b0, irq});
    endtask

    initial begin
        rst = 1'b1; src = '0; rd_en = 1'b0; wr_en = 1'b0;
        addr = '0; wr_data = '0; wr_strobe = '0;
        idle(3);
        rst = 1'b0;
        chk_irq("rst_irq", 1'b0);
        chk_rd("rst_enable", 6'h01, 32'h0);
        chk_rd("rst_pending", 6'h00, 32'h0);
        chk_rd("rst_thresh", 6'h03, 32'h0);
        chk_rd("rst_prio3", 6'h23, 32'h0);

        // level source ID3 and its latency
        wr(6'h23, 32'd2); wr(6'h01, 32'h8); wr(6'h03, 32'h0);
        src[2] = 1'b1;
        idle(2);
        chk_rd("lvl_pend_early", 6'h00, 32'h0);
        chk_irq("lvl_irq_early", 1'b0);
        chk_rd("lvl_pend", 6'h00, 32'h8);
        chk_irq("lvl_irq", 1'b1);
        chk_rd("lvl_claim", 6'h04, 32'd3);
        chk_irq("lvl_irq_hold", 1'b1);
        chk_rd("lvl_pend_clr", 6'h00, 32'h0);
        chk_irq("lvl_irq_drop", 1'b0);
        chk_rd("lvl_insvc", 6'h05, 32'h8);
        idle(3);
        chk_irq("lvl_masked", 1'b0);
        wr(6'h04, 32'd3);
        chk_irq("lvl_cmp_n", 1'b0);
        idle(1);
        chk_irq("lvl_cmp_n1", 1'b0);
        idle(1);
        chk_irq("lvl_reassert", 1'b1);
        src[2] = 1'b0;
        idle(3);
        chk_rd("lvl_claim2", 6'h04, 32'd3);
        wr(6'h04, 32'd3);
        idle(2);
        chk_irq("lvl_quiet", 1'b0);

        // priority order and ties
        wr(6'h21, 32'd1); wr(6'h22, 32'd4); wr(6'h25, 32'd4);
        wr(6'h02, 32'h26); wr(6'h01, 32'h26);
        src[0] = 1'b1; src[1] = 1'b1; src[4] = 1'b1;
        idle(4);
        chk_rd("pri_pend", 6'h00, 32'h26);
        chk_rd("pri_claim_a", 6'h04, 32'd2);
        chk_rd("pri_claim_b", 6'h04, 32'd5);
        chk_rd("pri_claim_c", 6'h04, 32'd1);
        chk_rd("pri_claim_none", 6'h04, 32'd0);
        chk_rd("pri_insvc", 6'h05, 32'h26);
        src = '0;
        wr(6'h04, 32'd1); wr(6'h04, 32'd2); wr(6'h04, 32'd5);
        chk_rd("pri_insvc_clr", 6'h05, 32'h0);
        idle(2);
        chk_irq("pri_quiet", 1'b0);

        // threshold gating
        wr(6'h26, 32'd4); wr(6'h02, 32'h40); wr(6'h01, 32'h40); wr(6'h03, 32'd4);
        src[5] = 1'b1;
        idle(4);
        chk_irq("thr_block", 1'b0);
        chk_rd("thr_pend", 6'h00, 32'h40);
        wr(6'h03, 32'd3);
        chk_irq("thr_edge_w", 1'b0);
        idle(1);
        chk_irq("thr_edge_w1", 1'b1);
        chk_rd("thr_claim", 6'h04, 32'd6);
        wr(6'h04, 32'd6);
        src[5] = 1'b0;

        // edge re-trigger colliding with the claim
        wr(6'h24, 32'd5); wr(6'h02, 32'h10); wr(6'h01, 32'h10);
        src[3] = 1'b1;
        idle(3);
        src[3] = 1'b0;
        idle(3);
        chk_rd("col_pend0", 6'h00, 32'h10);
        src[3] = 1'b1;
        idle(2);
        chk_rd("col_claim", 6'h04, 32'd4);
        chk_rd("col_pend_kept", 6'h00, 32'h10);
        chk_rd("col_excluded", 6'h04, 32'd0);
        chk_irq("col_irq", 1'b0);
        wr(6'h04, 32'd4);
        chk_rd("col_reclaim", 6'h04, 32'd4);
        wr(6'h04, 32'd4);
        src[3] = 1'b0;

        // bus rules
        wr(6'h01, 32'h0);
        wr(6'h01, 32'hFFFF_FFFF, 4'h2);
        chk_rd("bus_en_strobe", 6'h01, 32'h700);
        wr(6'h00, 32'hFFFF_FFFF);
        chk_rd("bus_pend_ro", 6'h00, 32'h0);
        chk_rd("bus_unmapped", 6'h10, 32'h0);
        chk_rd("bus_prio_oob", 6'h2B, 32'h0);
        wr(6'h21, 32'hFF);
        chk_rd("bus_prio_mask", 6'h21, 32'd7);
        wr(6'h03, 32'hFF, 4'h2);
        chk_rd("bus_thr_lane", 6'h03, 32'd3);
        addr = 6'h01;
        #1;
        sb.push_back('{"bus_rd_idle", 32'h0});
        compare(rd_data);
        idle(1);
        wr(6'h01, 32'h0);

        // mid-run reset with pending=0x006, in_service=0x008
        wr(6'h23, 32'd7); wr(6'h21, 32'd1); wr(6'h22, 32'd1);
        wr(6'h02, 32'h0); wr(6'h01, 32'h8); wr(6'h03, 32'h0);
        src[2] = 1'b1;
        idle(4);
        chk_rd("mr_claim", 6'h04, 32'd3);
        wr(6'h01, 32'h0);
        src[0] = 1'b1; src[1] = 1'b1;
        idle(4);
        src = '0;
        chk_rd("mr_pend", 6'h00, 32'h6);
        chk_rd("mr_insvc", 6'h05, 32'h8);
        wr(6'h04, 32'd0);
        wr(6'h04, 32'd31);
        chk_rd("mr_cmp_ignored", 6'h05, 32'h8);
        wr(6'h01, 32'h6);
        idle(1);
        chk_irq("mr_irq_on", 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_irq("mr_irq_async", 1'b0);
        chk_rd("mr_rst_pend", 6'h00, 32'h0);
        chk_rd("mr_rst_insvc", 6'h05, 32'h0);
        chk_rd("mr_rst_en", 6'h01, 32'h0);
        chk_rd("mr_rst_mode", 6'h02, 32'h0);
        chk_rd("mr_rst_prio3", 6'h23, 32'h0);
        rst = 1'b0;
        idle(2);
        chk_irq("mr_irq_after", 1'b0);
        chk_rd("mr_pend_after", 6'h00, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
